// File: rtl/signed_seq_divider.sv
// Sequential signed divider: sign-magnitude wrapper around a restoring
// shift-subtract core producing one quotient bit per clock.
module signed_seq_divider #(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div_by_zero,
    output logic         overflow
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N:0]    rem_q, rem_d;
    logic [N-1:0]  dvd_q, dvd_d;
    logic [N-1:0]  bmag_q, bmag_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  r_q, r_d;
    logic          sa_q, sa_d;
    logic          sb_q, sb_d;
    logic          dz_pend_q, dz_pend_d;
    logic          ov_pend_q, ov_pend_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          dz_q, dz_d;
    logic          ov_q, ov_d;

    logic [N-1:0]  a_abs, b_abs;
    logic [N:0]    shifted;
    logic [N+1:0]  trial;

    // Negating -2^(N-1) wraps to 2^(N-1), which is the correct unsigned magnitude.
    assign a_abs   = A[N-1] ? -A : A;
    assign b_abs   = B[N-1] ? -B : B;
    assign shifted = {rem_q[N-1:0], dvd_q[N-1]};
    assign trial   = {1'b0, shifted} - {2'b00, bmag_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        bmag_d    = bmag_q;
        a_d       = a_q;
        q_d       = q_q;
        r_d       = r_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        dz_pend_d = dz_pend_q;
        ov_pend_d = ov_pend_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        ov_d      = ov_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    sa_d      = A[N-1];
                    sb_d      = B[N-1];
                    dvd_d     = a_abs;
                    bmag_d    = b_abs;
                    a_d       = A;
                    dz_pend_d = (B == '0);
                    ov_pend_d = (A == {1'b1, {(N-1){1'b0}}}) && (B == '1);
                    rem_d     = '0;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = CALC;
                end
            end
            CALC: begin
                // Borrow out of the trial subtraction means the divisor did not fit.
                rem_d = trial[N+1] ? shifted : trial[N:0];
                dvd_d = {dvd_q[N-2:0], ~trial[N+1]};
                cnt_d = CW'(cnt_q + 1'b1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_pend_q) begin
                    q_d = '1;
                    r_d = a_q;
                end else begin
                    q_d = (sa_q ^ sb_q) ? -dvd_q : dvd_q;
                    r_d = sa_q ? -rem_q[N-1:0] : rem_q[N-1:0];
                end
                dz_d    = dz_pend_q;
                ov_d    = ov_pend_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            bmag_q    <= '0;
            a_q       <= '0;
            q_q       <= '0;
            r_q       <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            dz_pend_q <= 1'b0;
            ov_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            bmag_q    <= bmag_d;
            a_q       <= a_d;
            q_q       <= q_d;
            r_q       <= r_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            dz_pend_q <= dz_pend_d;
            ov_pend_q <= ov_pend_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            ov_q      <= ov_d;
        end
    end

    assign Q           = q_q;
    assign R           = r_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;
endmodule

// File: tb/tb_signed_seq_divider.sv
// Scoreboard bench: the driver pushes hand-computed results and the cycle
// they are due; a negedge monitor pops and compares on every done pulse.
module tb_signed_seq_divider;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [N-1:0] A, B;
    logic [N-1:0] Q, R;
    logic         busy, done, div_by_zero, overflow;

    typedef struct {
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
        logic         ov;
        int           due;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   ops_pushed = 0;
    int   dones_seen = 0;

    signed_seq_divider #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .Q(Q), .R(R), .busy(busy), .done(done),
        .div_by_zero(div_by_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: one comparison set per done pulse.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            dones_seen++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb_q.pop_front();
                chk("Q", int'(Q), int'(e.q));
                chk("R", int'(R), int'(e.r));
                chk("div_by_zero", int'(div_by_zero), int'(e.dz));
                chk("overflow", int'(overflow), int'(e.ov));
                chk("busy_at_done", int'(busy), 0);
                chk("done_cycle", cyc, e.due);
                $display("op done: Q=%0d R=%0d dz=%0b ov=%0b cycle=%0d",
                         $signed(Q), $signed(R), div_by_zero, overflow, cyc);
            end
        end
    end

    // Drive a start for one cycle (caller is positioned just after a negedge).
    task automatic issue(input int a, input int b, input int eq, input int er,
                         input logic edz, input logic eov);
        exp_t e;
        A     = N'(a);
        B     = N'(b);
        start = 1'b1;
        e.q   = N'(eq);
        e.r   = N'(er);
        e.dz  = edz;
        e.ov  = eov;
        e.due = cyc + N + 2;
        sb_q.push_back(e);
        ops_pushed++;
    endtask

    task automatic wait_done();
        bit seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        if (!seen) chk("done_timeout", 0, 1);
    endtask

    task automatic run_op(input int a, input int b, input int eq, input int er,
                          input logic edz, input logic eov);
        @(negedge clk);
        issue(a, b, eq, er, edz, eov);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        wait_done();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        A     = 5'd7;
        B     = 5'd2;
        repeat (2) @(negedge clk);
        chk("rst_Q", int'(Q), 0);
        chk("rst_R", int'(R), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_flags", int'({div_by_zero, overflow}), 0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);

        run_op(7, 2, 3, 1, 1'b0, 1'b0);
        run_op(-7, 2, -3, -1, 1'b0, 1'b0);
        run_op(7, -2, -3, 1, 1'b0, 1'b0);
        run_op(-16, 5, -3, -1, 1'b0, 1'b0);
        run_op(-16, -1, -16, 0, 1'b0, 1'b1);
        run_op(15, -16, 0, 15, 1'b0, 1'b0);
        run_op(5, 0, -1, 5, 1'b1, 1'b0);
        run_op(6, 3, 2, 0, 1'b0, 1'b0);

        // Start and input changes while busy must be ignored.
        @(negedge clk);
        issue(9, 4, 2, 1, 1'b0, 1'b0);
        @(negedge clk);
        A = 5'd1; B = 5'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            A = N'(i * 5 + 3);
            B = N'(i + 2);
        end
        @(negedge clk);
        start = 1'b0;
        wait_done();
        // Back-to-back start on the done cycle.
        issue(-9, 4, -2, -1, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset during CALC aborts without a done pulse.
        @(negedge clk);
        issue(13, 3, 4, 1, 1'b0, 1'b0);
        void'(sb_q.pop_back());
        ops_pushed--;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_Q", int'(Q), 0);
        chk("abort_R", int'(R), 0);
        chk("abort_busy", int'(busy), 0);
        repeat (10) @(negedge clk);
        chk("abort_busy_late", int'(busy), 0);
        run_op(13, 3, 4, 1, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("dones_seen", dones_seen, ops_pushed);
        chk("scoreboard_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
